// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute/memory/writeback sequencer with trap and retire counting
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_branch,
  output logic                 alu_src_imm,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, state_nx;
  logic [31:0] wait_cnt;
  logic is_r, is_i, is_ld, is_st, is_br, is_mem, legal, waiting, timeout, retire;
  assign is_r = opcode == 7'b0110011;
  assign is_i = opcode == 7'b0010011;
  assign is_ld = opcode == 7'b0000011;
  assign is_st = opcode == 7'b0100011;
  assign is_br = opcode == 7'b1100011;
  assign is_mem = is_ld || is_st;
  assign legal = is_r || is_i || is_mem || is_br;
  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  // this wait cycle is the MEM_TIMEOUT-th one; a ready in the same cycle is not a wait and wins
  assign timeout = waiting && MEM_TIMEOUT != 0 && wait_cnt >= 32'(MEM_TIMEOUT - 1);
  assign retire = (state == EXEC && is_br) || (state == MEM && dmem_ready && is_st) || state == WB;
  // next-state and per-state control strobes
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_branch = 1'b0;
    alu_src_imm = 1'b0;
    alu_op = 2'b00;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
        state_nx = imem_ready ? DECODE : timeout ? TRAP : FETCH;
      end
      DECODE: state_nx = legal ? EXEC : TRAP;
      EXEC: begin
        alu_op = is_br ? 2'b01 : is_mem ? 2'b00 : 2'b10;
        alu_src_imm = is_i || is_mem;
        pc_write = is_br && branch_taken;
        pc_branch = is_br && branch_taken;
        state_nx = is_br ? FETCH : is_mem ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_st;
        state_nx = dmem_ready ? (is_st ? FETCH : WB) : timeout ? TRAP : MEM;
      end
      WB: begin
        reg_write = 1'b1;
        mem_to_reg = is_ld;
        state_nx = FETCH;
      end
      default: state_nx = state;
    endcase
  end
  // state, wait counter, sticky trap and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      trap <= 1'b0;
      trap_cause <= 2'b00;
      retired <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= (state_nx != state) ? '0 : waiting ? wait_cnt + 32'd1 : wait_cnt;
      retired <= retired + CNT_WIDTH'(retire);
      if (state_nx == TRAP && state != TRAP) begin
        trap <= 1'b1;
        trap_cause <= (state == DECODE) ? 2'b01 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: vector table plus directed timeout/trap/reset sequences
module tb_multicycle_control_unit;
  logic clk = 1'b0, reset = 1'b1, branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_branch, alu_src_imm, reg_write, mem_to_reg, trap;
  logic [1:0] alu_op, trap_cause;
  logic [63:0] retired;
  int checks = 0, errors = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_X = 7'b1111111;
  localparam logic [13:0] IREQ = 14'h2000, DREQ = 14'h1000, WE = 14'h0800, IRW = 14'h0400;
  localparam logic [13:0] PCW = 14'h0200, PCB = 14'h0100, IMM = 14'h0080, AOP_F = 14'h0040;
  localparam logic [13:0] AOP_B = 14'h0020, RW = 14'h0010, M2R = 14'h0008, TRP = 14'h0004;
  localparam logic [13:0] C_ILL = 14'h0001, C_TO = 14'h0002, NONE = 14'h0000;
  localparam logic [13:0] FOK = IREQ | IRW | PCW;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       bt, ir, dr;
    logic [13:0] outs;
    int         ret;
  } vec_t;
  vec_t vecs[$];

  multicycle_control_unit #(.MEM_TIMEOUT(16), .CNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic [6:0] op, logic bt, logic ir, logic dr, logic [13:0] o, int ret);
    vec_t x;
    x.rst = r; x.op = op; x.bt = bt; x.ir = ir; x.dr = dr; x.outs = o; x.ret = ret;
    return x;
  endfunction

  function automatic logic [13:0] outs();
    return {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_branch, alu_src_imm, alu_op,
            reg_write, mem_to_reg, trap, trap_cause};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic bt, input logic ir, input logic dr);
    reset = r; opcode = op; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  task automatic next;
    @(negedge clk);
  endtask

  task automatic hold_trap(input string name, input logic [1:0] cause);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, OP_R, 1'b0, 1'b1, 1'b1);
      chk(name, {imem_req, dmem_req, trap, trap_cause}, {1'b0, 1'b0, 1'b1, cause});
      next();
    end
  endtask

  initial begin
    vecs.push_back(v(1, OP_R, 0, 1, 0, NONE, 0));
    vecs.push_back(v(0, OP_R, 0, 1, 0, NONE, 0));
    vecs.push_back(v(0, OP_R, 0, 1, 0, FOK, 0));
    vecs.push_back(v(0, OP_R, 0, 1, 0, NONE, 0));
    vecs.push_back(v(0, OP_R, 0, 1, 0, AOP_F, 0));
    vecs.push_back(v(0, OP_R, 0, 1, 0, RW, 0));
    vecs.push_back(v(0, OP_I, 0, 1, 0, FOK, 1));
    vecs.push_back(v(0, OP_I, 0, 1, 0, NONE, 1));
    vecs.push_back(v(0, OP_I, 0, 1, 0, AOP_F | IMM, 1));
    vecs.push_back(v(0, OP_I, 0, 1, 0, RW, 1));
    vecs.push_back(v(0, OP_L, 0, 0, 0, IREQ, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, FOK, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, NONE, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, IMM, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, DREQ, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, DREQ, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, DREQ, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 1, DREQ, 2));
    vecs.push_back(v(0, OP_L, 0, 1, 0, RW | M2R, 2));
    vecs.push_back(v(0, OP_S, 0, 1, 1, FOK, 3));
    vecs.push_back(v(0, OP_S, 0, 1, 1, NONE, 3));
    vecs.push_back(v(0, OP_S, 0, 1, 1, IMM, 3));
    vecs.push_back(v(0, OP_S, 0, 1, 1, DREQ | WE, 3));
    vecs.push_back(v(0, OP_B, 1, 1, 0, FOK, 4));
    vecs.push_back(v(0, OP_B, 1, 1, 0, NONE, 4));
    vecs.push_back(v(0, OP_B, 1, 1, 0, AOP_B | PCW | PCB, 4));
    vecs.push_back(v(0, OP_B, 1, 1, 0, FOK, 5));
    vecs.push_back(v(0, OP_B, 0, 1, 0, NONE, 5));
    vecs.push_back(v(0, OP_B, 0, 1, 0, AOP_B, 5));
    vecs.push_back(v(0, OP_X, 0, 1, 0, FOK, 6));
    vecs.push_back(v(0, OP_X, 0, 1, 0, NONE, 6));
    vecs.push_back(v(0, OP_X, 0, 1, 1, TRP | C_ILL, 6));
    vecs.push_back(v(1, OP_X, 0, 1, 1, TRP | C_ILL, 6));
    vecs.push_back(v(0, OP_R, 0, 0, 0, NONE, 0));

    next(); next();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].bt, vecs[i].ir, vecs[i].dr);
      chk($sformatf("vec%0d", i), {outs(), retired}, {vecs[i].outs, 64'(vecs[i].ret)});
      next();
    end

    // fetch wait of 16 cycles with no ready traps with cause 10
    drive(1'b1, OP_R, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0); next();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d", i), {imem_req, trap}, 2'b10);
      next();
    end
    hold_trap("to_hold", 2'b10);

    // ready on the 16th wait cycle wins over timeout
    drive(1'b1, OP_R, 1'b0, 1'b0, 1'b0); next();
    drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0); next();
    for (int i = 0; i < 15; i++) begin drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0); next(); end
    drive(1'b0, OP_R, 1'b0, 1'b1, 1'b0);
    chk("late_ready", {outs()}, {FOK});
    next();
    drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
    chk("late_decode", {outs()}, {NONE});
    next();
    drive(1'b0, OP_R, 1'b0, 1'b0, 1'b0);
    chk("late_exec", {outs()}, {AOP_F});
    next();

    // illegal opcode trap is absorbing and cleared only by reset
    drive(1'b1, OP_X, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, OP_X, 1'b0, 1'b1, 1'b0); next();
    next(); next();
    hold_trap("ill_hold", 2'b01);
    drive(1'b1, OP_X, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, OP_R, 1'b0, 1'b1, 1'b0);
    chk("ill_reset", {outs()}, {NONE});
    next();

    // reset during an outstanding store abandons it and clears retired
    drive(1'b1, OP_S, 1'b0, 1'b1, 1'b1); next();
    for (int i = 0; i < 5; i++) begin drive(1'b0, OP_S, 1'b0, 1'b1, 1'b1); next(); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, OP_S, 1'b0, 1'b1, 1'b0); next(); end
    drive(1'b0, OP_S, 1'b0, 1'b1, 1'b0);
    chk("st_mem", {outs(), retired}, {DREQ | WE, 64'd1});
    next();
    drive(1'b1, OP_S, 1'b0, 1'b1, 1'b0); next();
    drive(1'b0, OP_S, 1'b0, 1'b1, 1'b0);
    chk("st_reset", {outs(), retired}, {NONE, 64'd0});
    next();
    drive(1'b0, OP_S, 1'b0, 1'b1, 1'b0);
    chk("st_refetch", {outs(), retired}, {FOK, 64'd0});
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
